// File: rtl/delay_3_if.sv
// rtl/delay_3_if.sv - data bundle for the fixed three-stage delay pipeline
//
// Purpose: carries the datapath into and out of delay_3.
// Signals:
//   input_i   WIDTH  value sampled by the pipeline on every rising clock edge
//   output__  WIDTH  value leaving the pipeline, three edges after sampling
// Modports:
//   master  drives input_i, observes output__ (the producer/consumer side)
//   slave   observes input_i, drives output__ (the delay_3 side)

interface delay_3_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] input_i;
    logic [WIDTH-1:0] output__;

    modport master (
        output input_i,
        input  output__
    );

    modport slave (
        input  input_i,
        output output__
    );
endinterface

// File: rtl/delay_3.sv
// rtl/delay_3.sv - fixed three-stage register delay, no flow control
//
// Purpose: an input value appears on the output exactly three rising clock
// edges after it was sampled. Used as the reference basic pipeline and as a
// generic 3-cycle alignment delay for datapath signals.
// Ports:
//   clk_i     in   1      single clock, all state updates on the rising edge
//   rst_n_i   in   1      asynchronous-assert, active-low reset; release is
//                         expected synchronous to clk_i (no internal synchroniser)
//   bus       slave       input_i (sampled every edge) / output__ (stage-3 register)
// Parameters:
//   WIDTH     data width of the bus and of every stage (depth fixed at 3)

module delay_3 #(
    parameter int WIDTH = 8
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    delay_3_if.slave bus
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    // Reset clears every stage at once, so in-flight data is flushed and the
    // output reads zero for three edges after release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= bus.input_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Output is taken straight from the last register: no path from input_i.
    assign bus.output__ = s3;

endmodule

// File: tb/tb_delay_3.sv
// tb/tb_delay_3.sv - self-checking bench for delay_3

module tb_delay_3;

    localparam int WIDTH = 8;

    logic clk_i;
    logic rst_n_i;

    delay_3_if #(.WIDTH(WIDTH)) bus ();

    delay_3 #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the history of values accepted since the last reset. After k
    // accepted edges the output shows the value accepted at edge k-2, i.e. the
    // third most recent entry; with fewer than three entries it is zero.
    logic [WIDTH-1:0] hist[$];

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) hist.delete();
        else          hist.push_back(bus.input_i);
    end

    function automatic logic [WIDTH-1:0] model_out();
        if (hist.size() >= 3) return hist[hist.size() - 3];
        return '0;
    endfunction

    bit model_en = 1'b0;

    always @(negedge clk_i) begin
        if (model_en) check("model", bus.output__, model_out());
    end

    // Drive a value, let one rising edge sample it, settle just after the edge.
    task automatic tick(input logic [WIDTH-1:0] v);
        bus.input_i = v;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i     = 1'b1;
        bus.input_i = '0;
        #1 rst_n_i  = 1'b0;
        #1 check("reset_state", bus.output__, 8'h00);
        model_en = 1'b1;
        tick(8'h00);
        tick(8'h00);
        check("reset_held", bus.output__, 8'h00);
        rst_n_i = 1'b1;

        // single pulse
        tick(8'h01);
        tick(8'h00);
        check("pulse_pre", bus.output__, 8'h00);
        tick(8'h00);
        check("pulse_hit", bus.output__, 8'h01);
        tick(8'h00);
        check("pulse_after", bus.output__, 8'h00);

        // streaming
        tick(8'h11);
        tick(8'h22);
        tick(8'h33);
        check("stream_0", bus.output__, 8'h11);
        tick(8'h44);
        check("stream_1", bus.output__, 8'h22);
        tick(8'h00);
        check("stream_2", bus.output__, 8'h33);
        tick(8'h00);
        check("stream_3", bus.output__, 8'h44);

        // async reset with pipeline holding 0xAA,0x55,0xFF
        tick(8'hAA);
        tick(8'h55);
        tick(8'hFF);
        check("full_pipe", bus.output__, 8'hAA);
        #2 rst_n_i = 1'b0;
        #1 check("async_reset", bus.output__, 8'h00);
        tick(8'h12);
        tick(8'h34);
        check("reset_stays", bus.output__, 8'h00);
        rst_n_i = 1'b1;

        // reset mid-stream
        tick(8'h01);
        tick(8'h02);
        tick(8'h03);
        check("mid_pre", bus.output__, 8'h01);
        #2 rst_n_i = 1'b0;
        #1 check("mid_flush", bus.output__, 8'h00);
        tick(8'h04);
        tick(8'h05);
        rst_n_i = 1'b1;
        tick(8'h80);
        check("release_0", bus.output__, 8'h00);
        tick(8'h00);
        check("release_1", bus.output__, 8'h00);
        tick(8'h00);
        check("release_80", bus.output__, 8'h80);

        // extremes
        tick(8'hFF);
        tick(8'h00);
        tick(8'h00);
        check("ext_ff", bus.output__, 8'hFF);
        tick(8'hFF);
        check("ext_00", bus.output__, 8'h00);
        tick(8'h00);
        tick(8'h00);
        check("ext_ff2", bus.output__, 8'hFF);

        // held input
        for (int i = 1; i <= 10; i++) begin
            tick(8'h5A);
            if (i >= 3) check("held", bus.output__, 8'h5A);
        end
        repeat (4) tick(8'h00);
        check("drain", bus.output__, 8'h00);

        model_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
